// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one div_fast divider among N_REQ requesters.
// Optional DIV_ARB_ZERO_BYPASS_EN: zero divisors saturate locally without starting the divider.
module div_arbiter #(
  parameter int N_REQ    = 4,
  parameter int D_W      = 16,
  parameter int FRAC_BIT = 13,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                   I_CLK,
  input  logic                   I_RST,
  input  logic [N_REQ-1:0]       I_REQ,
  input  logic [N_REQ*D_W-1:0]   I_DIVIDEND,
  input  logic [N_REQ*D_W-1:0]   I_DIVISOR,
  output logic [N_REQ-1:0]       O_GNT,
  output logic                   O_RES_VLD,
  output logic [ID_W-1:0]        O_RES_ID,
  output logic [D_W-1:0]         O_QUOTIENT,
  output logic                   O_DIV_START,
  output logic [D_W-1:0]         O_DIV_DIVIDEND,
  output logic [D_W-1:0]         O_DIV_DIVISOR,
  input  logic [D_W-1:0]         I_DIV_QUOTIENT,
  input  logic                   I_DIV_VLD
);

  if (FRAC_BIT >= D_W) begin : g_frac_bit_too_wide
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic            xfer;
  logic [D_W-1:0]  win_dvd;
  logic [D_W-1:0]  win_dvs;

  // Search upward from last_id+1 so the lowest offset wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      int              s;
      logic [ID_W-1:0] idx;
      s = int'(last_id) + k;
      if (s >= N_REQ) s = s - N_REQ;
      idx = ID_W'(s);
      if (I_REQ[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    win_dvd = '0;
    win_dvs = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_dvd = I_DIVIDEND[i*D_W +: D_W];
        win_dvs = I_DIVISOR[i*D_W +: D_W];
      end
    end
  end

  assign xfer = (state == S_IDLE) && win_vld;

`ifdef DIV_ARB_ZERO_BYPASS_EN
  logic           zero_div;
  logic [D_W-1:0] sat_q;

  assign zero_div = xfer && (win_dvs == '0);

  always_comb begin
    sat_q = '0;
    if (win_dvd != '0)
      sat_q = win_dvd[D_W-1] ? {1'b1, {(D_W-1){1'b0}}}
                             : {1'b0, {(D_W-1){1'b1}}};
  end
`endif

  always_comb begin
    state_nxt   = state;
    O_GNT       = '0;
    O_DIV_START = 1'b0;
    O_RES_VLD   = 1'b0;
    O_RES_ID    = last_id;
    unique case (state)
      S_IDLE: begin
        for (int i = 0; i < N_REQ; i++)
          O_GNT[i] = win_vld && (win_id == ID_W'(i));
        if (xfer) begin
`ifdef DIV_ARB_ZERO_BYPASS_EN
          state_nxt = zero_div ? S_DONE : S_RUN;
`else
          state_nxt = S_RUN;
`endif
        end
      end
      S_RUN: begin
        O_DIV_START = 1'b1;
        if (I_DIV_VLD) state_nxt = S_DONE;
      end
      S_DONE: begin
        O_RES_VLD = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state          <= S_IDLE;
      last_id        <= ID_W'(N_REQ - 1);
      O_QUOTIENT     <= '0;
      O_DIV_DIVIDEND <= '0;
      O_DIV_DIVISOR  <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        last_id        <= win_id;
        O_DIV_DIVIDEND <= win_dvd;
        O_DIV_DIVISOR  <= win_dvs;
`ifdef DIV_ARB_ZERO_BYPASS_EN
        if (zero_div) O_QUOTIENT <= sat_q;
`endif
      end
      if (state == S_RUN && I_DIV_VLD)
        O_QUOTIENT <= I_DIV_QUOTIENT;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a 5-cycle div_fast stand-in.
module tb_div_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           I_CLK = 1'b0;
  logic           I_RST;
  logic [N-1:0]   I_REQ;
  logic [N*W-1:0] dvd;
  logic [N*W-1:0] dvs;
  logic [N-1:0]   O_GNT;
  logic           O_RES_VLD;
  logic [1:0]     O_RES_ID;
  logic [W-1:0]   O_QUOTIENT;
  logic           O_DIV_START;
  logic [W-1:0]   O_DIV_DIVIDEND;
  logic [W-1:0]   O_DIV_DIVISOR;
  logic [W-1:0]   I_DIV_QUOTIENT;
  logic           I_DIV_VLD;
  logic           force_vld;
  logic [3:0]     run_cnt = 4'd0;

  int n_chk  = 0;
  int n_pass = 0;

  div_arbiter #(.N_REQ(N), .D_W(W), .FRAC_BIT(13)) dut (
    .I_CLK          (I_CLK),
    .I_RST          (I_RST),
    .I_REQ          (I_REQ),
    .I_DIVIDEND     (dvd),
    .I_DIVISOR      (dvs),
    .O_GNT          (O_GNT),
    .O_RES_VLD      (O_RES_VLD),
    .O_RES_ID       (O_RES_ID),
    .O_QUOTIENT     (O_QUOTIENT),
    .O_DIV_START    (O_DIV_START),
    .O_DIV_DIVIDEND (O_DIV_DIVIDEND),
    .O_DIV_DIVISOR  (O_DIV_DIVISOR),
    .I_DIV_QUOTIENT (I_DIV_QUOTIENT),
    .I_DIV_VLD      (I_DIV_VLD)
  );

  always #5 I_CLK = ~I_CLK;

  // Stand-in divider: Q3.13 divide, valid on the 5th start cycle.
  function automatic logic [15:0] fx_div(input logic [15:0] a, input logic [15:0] b);
    int na;
    int nb;
    na = int'($signed(a));
    nb = int'($signed(b));
    if (nb == 0)
      return (a == 16'h0) ? 16'h0000 : (a[15] ? 16'h8000 : 16'h7FFF);
    return 16'((na * 8192) / nb);
  endfunction

  always @(posedge I_CLK)
    run_cnt <= O_DIV_START ? run_cnt + 4'd1 : 4'd0;

  assign I_DIV_VLD      = force_vld | (O_DIV_START & (run_cnt == 4'd4));
  assign I_DIV_QUOTIENT = force_vld ? 16'h1234
                                    : fx_div(O_DIV_DIVIDEND, O_DIV_DIVISOR);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic run_op(input int id, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_q,
                        input int exp_lat, input bit scr);
    int cyc;
    int starts;
    bit seen;
    dvd[id*W +: W] = a;
    dvs[id*W +: W] = b;
    I_REQ = 4'(1 << id);
    #1;
    chk("gnt", 32'(O_GNT), 32'(1 << id));
    tick();
    I_REQ = '0;
    if (scr) begin
      dvd[id*W +: W] = 16'h1111;
      dvs[id*W +: W] = 16'h0800;
    end
    cyc    = 1;
    starts = 0;
    seen   = 1'b0;
    while (cyc <= 20 && !seen) begin
      if (O_RES_VLD) seen = 1'b1;
      else begin
        if (O_DIV_START) starts++;
        tick();
        cyc++;
      end
    end
    chk("res_seen", 32'(seen), 32'd1);
    chk("latency", cyc, exp_lat);
    chk("res_id", 32'(O_RES_ID), id);
    chk("quotient", 32'(O_QUOTIENT), 32'(exp_q));
    chk("start_cycles", starts, exp_lat - 1);
    chk("start_in_done", 32'(O_DIV_START), 32'd0);
    tick();
  endtask

  initial begin
    int nv;
    int ng;
    int nr;
    int zlat;
    I_RST     = 1'b1;
    I_REQ     = '0;
    dvd       = '0;
    dvs       = '0;
    force_vld = 1'b0;
    tick();
    tick();
    I_RST = 1'b0;
    #1;
    chk("rst_gnt", 32'(O_GNT), 32'd0);
    chk("rst_vld", 32'(O_RES_VLD), 32'd0);
    chk("rst_start", 32'(O_DIV_START), 32'd0);
    chk("rst_q", 32'(O_QUOTIENT), 32'd0);
    chk("rst_dvd", 32'(O_DIV_DIVIDEND), 32'd0);
    chk("rst_dvs", 32'(O_DIV_DIVISOR), 32'd0);
    chk("rst_id", 32'(O_RES_ID), 32'd3);

    run_op(0, 16'h4000, 16'h2000, 16'h4000, 6, 1'b0);
    run_op(1, 16'hE000, 16'h2000, 16'hE000, 6, 1'b0);
    run_op(2, 16'h2000, 16'hC000, 16'hF000, 6, 1'b0);
    run_op(3, 16'h6000, 16'h4000, 16'h3000, 6, 1'b1);

`ifdef DIV_ARB_ZERO_BYPASS_EN
    zlat = 1;
`else
    zlat = 6;
`endif
    run_op(0, 16'h2000, 16'h0000, 16'h7FFF, zlat, 1'b0);

    force_vld = 1'b1;
    tick();
    force_vld = 1'b0;
    chk("stray_vld_res", 32'(O_RES_VLD), 32'd0);
    chk("stray_vld_q", 32'(O_QUOTIENT), 32'h7FFF);

    dvd[1*W +: W] = 16'h2000;
    dvs[1*W +: W] = 16'h2000;
    I_REQ = 4'b0010;
    #1;
    chk("mid_rst_gnt", 32'(O_GNT), 32'h2);
    tick();
    I_REQ = '0;
    tick();
    tick();
    chk("start_c3", 32'(O_DIV_START), 32'd1);
    I_RST = 1'b1;
    tick();
    I_RST = 1'b0;
    chk("start_c4", 32'(O_DIV_START), 32'd0);
    nv = 0;
    repeat (10) begin
      if (O_RES_VLD) nv++;
      tick();
    end
    chk("no_vld_after_rst", nv, 0);
    I_REQ = 4'hF;
    #1;
    chk("gnt_after_rst", 32'(O_GNT), 32'h1);
    tick();
    I_REQ = '0;
    nv = 0;
    while (nv < 20 && !O_RES_VLD) begin
      tick();
      nv++;
    end
    chk("post_rst_done", 32'(O_RES_VLD), 32'd1);
    tick();

    I_RST = 1'b1;
    tick();
    I_RST = 1'b0;
    for (int i = 0; i < N; i++) begin
      dvd[i*W +: W] = 16'(16'h1000 * (i + 1));
      dvs[i*W +: W] = 16'h2000;
    end
    I_REQ = 4'hF;
    #1;
    ng = 0;
    nr = 0;
    for (int cyc = 0; cyc < 35; cyc++) begin
      if (O_GNT != '0) begin
        chk("fair_gnt", 32'(O_GNT), 32'(1 << (ng % 4)));
        chk("fair_cyc", cyc, ng * 7);
        ng++;
      end
      if (O_RES_VLD) begin
        chk("fair_id", 32'(O_RES_ID), nr % 4);
        chk("fair_q", 32'(O_QUOTIENT), 32'h1000 * (nr % 4 + 1));
        nr++;
      end
      tick();
    end
    I_REQ = '0;
    chk("fair_ngrants", ng, 5);
    chk("fair_nres", nr, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one div_fast instance (2..8).
REQ-002 Parameter D_W, default 16: operand and quotient width, two's complement.
REQ-003 Parameter FRAC_BIT, default 13: fraction bits, matching the attached div_fast.
REQ-004 I_CLK  in  1  sole clock; reset is synchronous and active-high.
REQ-005 I_RST  in  1  synchronous active-high reset.
REQ-006 I_REQ  in  N_REQ  per-requester request valid.
REQ-007 I_DIVIDEND  in  N_REQ*D_W  packed dividends; requester i at bits [i*D_W +: D_W].
REQ-008 I_DIVISOR  in  N_REQ*D_W  packed divisors, same packing.
REQ-009 O_GNT  out  N_REQ  one-hot grant; a request transfers when I_REQ[i] and O_GNT[i] are both high.
REQ-010 O_RES_VLD  out  1  one-cycle result strobe.
REQ-011 O_RES_ID  out  $clog2(N_REQ)  index of the requester owning the result.
REQ-012 O_QUOTIENT  out  D_W  result, Q(D_W-FRAC_BIT).FRAC_BIT.
REQ-013 O_DIV_START  out  1  drives div_fast I_DIV_START.
REQ-014 O_DIV_DIVIDEND / O_DIV_DIVISOR  out  D_W each  drive div_fast operands; registered.
REQ-015 I_DIV_QUOTIENT  in  D_W  div_fast O_QUOTIENT.
REQ-016 I_DIV_VLD  in  1  div_fast O_VLD.

Function
REQ-017 The FSM SHALL have states S_IDLE, S_RUN and S_DONE.
REQ-018 In S_IDLE, O_GNT SHALL be the combinational round-robin winner among I_REQ, searched upward from last_id+1 and wrapping; with no request, O_GNT SHALL be 0.
REQ-019 On the transfer edge, the block SHALL register the winner's operands into O_DIV_DIVIDEND/O_DIV_DIVISOR, set last_id to the winner, and move to S_RUN.
REQ-020 O_GNT SHALL be 0 in S_RUN and S_DONE; requests are not queued.
REQ-021 O_DIV_START SHALL be high exactly while in S_RUN; operands SHALL remain stable from S_RUN entry through the S_DONE cycle.
REQ-022 In S_RUN with I_DIV_VLD high, the block SHALL capture I_DIV_QUOTIENT into O_QUOTIENT and move to S_DONE.
REQ-023 In S_DONE, O_RES_VLD SHALL be high for exactly one cycle, with O_RES_ID equal to last_id; the next state SHALL be S_IDLE.
REQ-024 Latency: with the handshake in cycle 0, O_DIV_START is high in cycles 1-5, I_DIV_VLD arrives in cycle 5, O_RES_VLD is high in cycle 6, and the earliest next grant is in cycle 7.
REQ-025 O_DIV_START SHALL be low in the S_DONE cycle, while div_fast is in its output state, so it does not restart.
REQ-026 I_DIV_VLD seen outside S_RUN SHALL be ignored.
REQ-027 Changes to a requester's operands or I_REQ after its transfer SHALL NOT affect the in-flight operation.
REQ-028 A requester holding I_REQ high after transfer SHALL be eligible again only after the other pending requesters have been served (round-robin fairness).

Reset
REQ-029 While I_RST is high at a clock edge, the block SHALL enter S_IDLE, clear O_DIV_START, O_RES_VLD, O_QUOTIENT, O_DIV_DIVIDEND and O_DIV_DIVISOR to 0, and set last_id to N_REQ-1, so requester 0 has first priority.
REQ-030 Reset in S_RUN SHALL drop O_DIV_START in the following cycle and discard the in-flight result; no O_RES_VLD SHALL follow.

Configuration
REQ-031 Macro DIV_ARB_ZERO_BYPASS_EN defined: a transferred divisor of 0 SHALL skip S_RUN (S_IDLE -> S_DONE) with O_DIV_START held low.
REQ-032 In that bypass case, O_QUOTIENT SHALL be 0 for dividend 0, the maximum positive value (0x7FFF at D_W=16) for a positive dividend, and the minimum value (0x8000) for a negative dividend, with O_RES_VLD in cycle 1.
REQ-033 Macro DIV_ARB_ZERO_BYPASS_EN undefined: a divisor of 0 SHALL be sent to div_fast like any other, with the REQ-024 timing.

Verification
REQ-034 Single request: req0 with 0x4000/0x2000 -> O_GNT=0001 in cycle 0; O_RES_VLD in cycle 6 with ID=0 and quotient 0x4000.
REQ-035 All four requesting continuously from reset -> grant order 0,1,2,3,0; consecutive grants 7 cycles apart; each ID matches its operands.
REQ-036 Signed case: 0xE000/0x2000 -> 0xE000; 0x2000/0xC000 -> 0xF000.
REQ-037 I_RST pulsed in cycle 3 of an operation -> O_DIV_START low in cycle 4; no O_RES_VLD; next request granted to requester 0.
REQ-038 Bypass on: 0x2000/0x0000 -> O_RES_VLD in cycle 1 with 0x7FFF and O_DIV_START never high; bypass off: the same stimulus gives O_RES_VLD in cycle 6.
REQ-039 Operands of the granted requester changed in cycle 1 -> result still matches the operands captured in cycle 0.
